ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, host clock-inhibit time in microseconds.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15, limit from inhibit release to ACK completion.
REQ-004 SHALL have port clk  in  1  system clock; one clock domain; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-006 SHALL have port tx_data  in  8  command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid  in  1  request; accepted when tx_valid & tx_ready.
REQ-008 SHALL have port tx_ready  out  1  high only in IDLE.
REQ-009 SHALL have port ps2_clk_i  in  1  raw PS2_CLK line state (asynchronous).
REQ-010 SHALL have port ps2_data_i  in  1  raw PS2_DATA line state (asynchronous).
REQ-011 SHALL have port ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release (open-drain).
REQ-012 SHALL have port ps2_data_oe  out  1  1 = pull PS2_DATA low; 0 = release.
REQ-013 SHALL have port tx_done  out  1  one-cycle pulse on acknowledged completion.
REQ-014 SHALL have port tx_err  out  1  one-cycle pulse on NACK or timeout.

Function
REQ-015 ps2_clk_i/ps2_data_i SHALL pass a 2-FF synchronizer; "fall" = synchronized clock 1->0, detected one cycle after synchronizer output.
REQ-016 States SHALL be IDLE, INHIBIT, SHIFT, ACK, WAITIDLE.
REQ-017 IDLE: both oe = 0; on accept, latch tx_data, compute parity = ~^tx_data (odd), clear bit counter, go INHIBIT next cycle.
REQ-018 INHIBIT: ps2_clk_oe = 1 for exactly CLK_HZ/1_000_000*INHIBIT_US cycles (10_000 at defaults); ps2_data_oe = 1 asserted in its final cycle (start bit 0); then SHIFT.
REQ-019 SHIFT: ps2_clk_oe = 0; on falls 1..8 drive data bit fall-1 (LSB first; oe = ~bit); fall 9 drive parity; fall 10 ps2_data_oe = 0 (stop); then ACK.
REQ-020 ACK: on next fall sample synchronized data; 0 -> WAITIDLE; 1 -> tx_err pulse, IDLE.
REQ-021 WAITIDLE: when synchronized clock and data both 1, pulse tx_done, go IDLE.
REQ-022 Falls seen in IDLE or INHIBIT SHALL be ignored; tx_valid outside IDLE SHALL be ignored, tx_data not re-latched.
REQ-023 tx_done and tx_err SHALL never assert in the same cycle; tx_ready SHALL return high the cycle after either pulse.

Reset
REQ-024 rst low SHALL immediately force IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_done = 0, tx_err = 0, tx_ready = 1, counters and synchronizers cleared (synchronizers to 1), including mid-frame.

Configuration
REQ-025 Macro PS2_TX_TIMEOUT_EN defined: watchdog counts from INHIBIT exit; reaching CLK_HZ/1000*TIMEOUT_MS cycles in SHIFT/ACK/WAITIDLE releases both lines, pulses tx_err, returns IDLE.
REQ-026 Macro undefined: no watchdog logic; tx_err only on NACK; a stalled device holds the block out of IDLE until reset.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the state enum, PS2 frame length (11) and the LSB-first/odd-parity constants, shared with the PS2 receiver.
REQ-028 Sub-module ps2_sync_edge SHALL contain the 2-FF synchronizers and falling-edge detector, reusable by the receiver.

Verification
REQ-029 Send 0xED, device model clocks 11 falls at 12.5 kHz and ACKs -> data-line bits 0,1,0,1,1,0,1,1,1 (parity 1), stop released, one tx_done, no tx_err.
REQ-030 Send 0xFF -> parity bit 1 driven on fall 9 (0xFF has 8 ones, odd needs 1); 0x00 -> parity 1; 0x01 -> parity 0.
REQ-031 Device leaves data high on fall 11 -> one tx_err, tx_ready high next cycle, both oe 0.
REQ-032 PS2_TX_TIMEOUT_EN defined, device sends only 4 falls -> tx_err at 1_500_000 cycles after INHIBIT exit; undefined -> block stays out of IDLE.
REQ-033 rst low at fall 5 -> both oe 0 asynchronously; after release, new 0xF4 send completes with tx_done.
REQ-034 Hold tx_valid high through a frame with tx_data changed to 0x55 mid-frame -> original byte transmitted intact, exactly one frame per accept.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame constants, FSM state enum and bit helpers shared by host TX and receiver
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_LEN  = 11;    // start + 8 data + parity + stop
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam bit          PS2_LSB_FIRST  = 1'b1;
  localparam bit          PS2_ODD_PARITY = 1'b1;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic ps2_parity(input logic [7:0] d);
    return PS2_ODD_PARITY ? ~^d : ^d;
  endfunction

  // Data bit transmitted in slot idx of the frame body.
  function automatic logic ps2_data_bit(input logic [7:0] d, input logic [2:0] idx);
    return PS2_LSB_FIRST ? d[idx] : d[3'd7 - idx];
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF synchronizers for PS2 clock/data and falling-edge detect on the clock
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic fall_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  // Idle bus level is high, so everything resets to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_sync_o  = clk_sync_q;
  assign data_sync_o = data_sync_q;
  assign fall_o      = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; optional watchdog via PS2_TX_TIMEOUT_EN
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int unsigned INH_W       = (INHIBIT_CYC > 2) ? $clog2(INHIBIT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [3:0] PARITY_IDX = 4'(PS2_DATA_BITS);      // fall 9 drives parity
  localparam logic [3:0] STOP_IDX   = 4'(PS2_FRAME_LEN - 2);  // fall 10 releases for stop

  ps2_state_e       state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             data_oe_q, data_oe_d;
  logic             clk_sync, data_sync, fall;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .clk_sync_o  (clk_sync),
    .data_sync_o (data_sync),
    .fall_o      (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned WD_W   = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_active;

  assign wd_active = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAITIDLE);

  // Watchdog runs from inhibit release until the frame leaves the bus phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           wd_q <= '0;
    else if (wd_active) wd_q <= wd_q + WD_W'(1);
    else                wd_q <= '0;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Next-state and line/handshake outputs.
  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = inh_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    data_oe_d   = data_oe_q;
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_ready  = 1'b1;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = ps2_parity(tx_data);
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          ps2_data_oe = 1'b1;  // start bit set up before clock release
          data_oe_d   = 1'b1;
          state_d     = ST_SHIFT;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = data_oe_q;
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < PARITY_IDX) begin
            data_oe_d = ~ps2_data_bit(shift_q, bit_cnt_q[2:0]);
          end else if (bit_cnt_q == PARITY_IDX) begin
            data_oe_d = ~parity_q;
          end else if (bit_cnt_q == STOP_IDX) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          if (data_sync) begin
            tx_err  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAITIDLE;
          end
        end
      end
      ST_WAITIDLE: begin
        if (clk_sync && data_sync) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // A stalled device aborts the frame; the error wins over any same-cycle completion.
    if (wd_active && (wd_q == WD_LAST)) begin
      tx_done   = 1'b0;
      tx_err    = 1'b1;
      data_oe_d = 1'b0;
      state_d   = ST_IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a clocking PS/2 device model
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 1_000_000;
  localparam int INHIBIT_US = 20;
  localparam int TIMEOUT_MS = 1;
  localparam int INH_CYC    = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC     = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int H          = 8;  // device half-period in system clocks

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  wire        clk_line  = dev_clk & ~ps2_clk_oe;
  wire        data_line = dev_dat & ~ps2_data_oe;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int cyc = 0, err_cyc = 0;
  bit pend = 1'b0;

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pulse bookkeeping and per-pulse checks, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (tx_done === 1'b1 || tx_err === 1'b1) begin
      n_chk++;
      if (tx_done === 1'b1 && tx_err === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_exclusive: done=%b err=%b, required not both", tx_done, tx_err);
      end
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
      pend = 1'b1;
    end else if (pend) begin
      pend = 1'b0;
      n_chk++;
      if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_after_pulse: ready=%b clk_oe=%b data_oe=%b, required 1 0 0",
                 tx_ready, ps2_clk_oe, ps2_data_oe);
      end
    end
    if (rst && tx_valid && tx_ready === 1'b1) acc_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Expected line levels: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_req(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (tx_ready === 1'b0) break;
    end
    tx_valid = 1'b0;
  endtask

  // Device: observe inhibit, clock nf falls, sample data while clock low, optionally ACK.
  task automatic device_frame(input int nf, input bit ack, output logic [10:0] cap,
                              output int inh_len, output int rel_cyc, output bit ok);
    int w;
    cap = '1; inh_len = 0; rel_cyc = 0; ok = 1'b1;
    w = 0;
    while (ps2_clk_oe !== 1'b1 && w < 300) begin tick; w++; end
    if (w >= 300) begin ok = 1'b0; return; end
    while (ps2_clk_oe === 1'b1 && inh_len < 300) begin inh_len++; tick; end
    rel_cyc = cyc;
    cap[0] = data_line;
    for (int i = 1; i <= nf; i++) begin
      if (i == 11 && ack) dev_dat = 1'b0;
      repeat (H) tick;
      dev_clk = 1'b0;
      repeat (H) tick;
      if (i <= 10) cap[i] = data_line;
      dev_clk = 1'b1;
      if (i == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input string name);
    int d0 = done_cnt, e0 = err_cnt, il, rc;
    logic [10:0] cap, exp;
    bit ok;
    exp = frame_model(b);
    fork
      start_req(b);
      device_frame(11, ack, cap, il, rc, ok);
    join
    repeat (10) tick;
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_handshake: no inhibit seen, required inhibit", name); end
    n_chk++;
    if (cap !== exp) begin n_fail++; $display("FAIL %s_frame: got %b, required %b", name, cap, exp); end
    n_chk++;
    if (il !== INH_CYC) begin n_fail++; $display("FAIL %s_inhibit_len: got %0d, required %0d", name, il, INH_CYC); end
    n_chk++;
    if ((done_cnt - d0) !== (ack ? 1 : 0) || (err_cnt - e0) !== (ack ? 0 : 1)) begin
      n_fail++;
      $display("FAIL %s_result: done=%0d err=%0d, required done=%0d err=%0d",
               name, done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
    end
    n_chk++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: ready=%b clk_oe=%b data_oe=%b, required 1 0 0", name, tx_ready, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick;
    n_chk++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b clk_oe=%b data_oe=%b done=%b err=%b, required 1 0 0 0 0",
               tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err);
    end
    rst = 1'b1;
    repeat (2) tick;
    n_chk++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 1", tx_ready); end
  endtask

  task automatic test_known_bytes;
    run_frame(8'hED, 1'b1, "byte_ed");
    run_frame(8'hFF, 1'b1, "byte_ff");
    run_frame(8'h00, 1'b1, "byte_00");
    run_frame(8'h01, 1'b1, "byte_01");
  endtask

  task automatic test_nack;
    run_frame(8'(($urandom)), 1'b0, "nack");
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        dev_clk = 1'b0;
        repeat (4) tick;
        dev_clk = 1'b1;
        repeat (4) tick;
      end
      n_chk++;
      if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_fall_ignored: ready=%b clk_oe=%b, required 1 0", tx_ready, ps2_clk_oe);
      end
      run_frame(8'($urandom), ($urandom_range(3, 0) != 0), "random");
    end
  endtask

  task automatic test_async_reset;
    logic [10:0] cap;
    int il, rc;
    bit ok;
    fork
      start_req(8'hA7);
      device_frame(4, 1'b0, cap, il, rc, ok);
    join
    repeat (H) tick;
    dev_clk = 1'b0;
    repeat (5) tick;
    n_chk++;
    if (ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_bit4: data_oe=%b clk_oe=%b, required 1 0", ps2_data_oe, ps2_clk_oe);
    end
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: clk_oe=%b data_oe=%b ready=%b, required 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    tick;
    dev_clk = 1'b1;
    repeat (3) tick;
    rst = 1'b1;
    repeat (3) tick;
    run_frame(8'hF4, 1'b1, "f4_after_reset");
  endtask

  task automatic test_timeout;
    logic [10:0] cap;
    int il, rc, e0;
    bit ok;
    e0 = err_cnt;
    fork
      start_req(8'h9A);
      device_frame(4, 1'b0, cap, il, rc, ok);
    join
`ifdef PS2_TX_TIMEOUT_EN
    for (int i = 0; i < TO_CYC + 200 && err_cnt == e0; i++) tick;
    repeat (3) tick;
    n_chk++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d, required 1", err_cnt - e0); end
    n_chk++;
    if (err_cyc - rc < TO_CYC - 2 || err_cyc - rc > TO_CYC + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d, required %0d", err_cyc - rc, TO_CYC);
    end
    n_chk++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: ready=%b clk_oe=%b data_oe=%b, required 1 0 0", tx_ready, ps2_clk_oe, ps2_data_oe);
    end
`else
    repeat (TO_CYC + 500) tick;
    n_chk++;
    if (tx_ready !== 1'b0 || err_cnt !== e0) begin
      n_fail++;
      $display("FAIL stall_hold: ready=%b errs=%0d, required 0 0", tx_ready, err_cnt - e0);
    end
    rst = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    repeat (2) tick;
    n_chk++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL stall_recover: ready=%b, required 1", tx_ready); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [10:0] cap_a, cap_b;
    int il, rc, d0, e0, a0;
    bit ok_a, ok_b;
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    fork
      device_frame(11, 1'b1, cap_a, il, rc, ok_a);
      begin
        for (int i = 0; i < 300; i++) begin tick; if (tx_ready === 1'b0) break; end
        repeat (60) tick;
        tx_data = 8'h55;
      end
    join
    fork
      device_frame(11, 1'b1, cap_b, il, rc, ok_b);
      begin
        for (int i = 0; i < 300; i++) begin if (tx_ready === 1'b1) break; tick; end
        for (int i = 0; i < 300; i++) begin if (tx_ready === 1'b0) break; tick; end
        tx_valid = 1'b0;
      end
    join
    repeat (50) tick;
    n_chk++;
    if (!ok_a || cap_a !== frame_model(8'h3C)) begin
      n_fail++;
      $display("FAIL b2b_first: got %b, required %b", cap_a, frame_model(8'h3C));
    end
    n_chk++;
    if (!ok_b || cap_b !== frame_model(8'h55)) begin
      n_fail++;
      $display("FAIL b2b_second: got %b, required %b", cap_b, frame_model(8'h55));
    end
    n_chk++;
    if (acc_cnt - a0 !== 2 || done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_counts: accepts=%0d done=%0d err=%0d, required 2 2 0",
               acc_cnt - a0, done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset;
    test_known_bytes;
    test_nack;
    test_random;
    test_async_reset;
    test_back_to_back;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
